// File: rtl/ip_fifo_wr_arb_if.sv
// Producer/FIFO-facing bundle of the ip_fifo write-port arbiter.
// slave = arbiter side, master = producers plus the FIFO full flag.
interface ip_fifo_wr_arb_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int OW = $clog2(N);

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] din;
  logic [N-1:0]       gnt;
  logic [N-1:0]       ready;
  logic [OW-1:0]      owner;
  logic               busy;
  logic               fifo_wr_en;
  logic [WIDTH-1:0]   fifo_din;
  logic               fifo_full;

  modport master (
    output req, din, fifo_full,
    input  gnt, ready, owner, busy, fifo_wr_en, fifo_din
  );

  modport slave (
    input  req, din, fifo_full,
    output gnt, ready, owner, busy, fifo_wr_en, fifo_din
  );
endinterface

// File: rtl/ip_fifo_wr_arb.sv
// Round-robin burst arbiter for the single ip_fifo write port: one owner at a
// time for up to MAX_BURST beats, FIFO full passed straight back to the owner.
module ip_fifo_wr_arb_lane (
  input  logic gnt,
  input  logic fifo_full,
  output logic ready
);
  assign ready = gnt & ~fifo_full;
endmodule

module ip_fifo_wr_arb #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ip_fifo_wr_arb_if.slave   bus
);
  localparam int OW = $clog2(N);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state, state_nxt;
  logic [N-1:0]             gnt_q;
  logic [N-1:0]             ready_w;
  logic [OW-1:0]            owner_q, ptr_q, owner_inc, base, pick;
  logic [CW-1:0]            beat_cnt;
  logic                     found, beat, rel, busy_w;
  logic [N-1:0][WIDTH-1:0]  din_v;

  assign din_v     = bus.din;
  assign busy_w    = (state == BUSY);
  assign beat      = busy_w & bus.req[owner_q] & ~bus.fifo_full;
  assign rel       = busy_w & ((beat & (beat_cnt == CW'(MAX_BURST - 1))) | ~bus.req[owner_q]);
  assign owner_inc = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);
  // On release the scan starts just past the owner, so the owner itself is
  // checked last and can be re-granted without an idle bubble.
  assign base      = busy_w ? owner_inc : ptr_q;

  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(base) + k) % N;
      if (bus.req[idx]) begin
        pick  = OW'(idx);
        found = 1'b1;
      end
    end
  end

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_lane
      ip_fifo_wr_arb_lane u_lane (
        .gnt       (gnt_q[i]),
        .fifo_full (bus.fifo_full),
        .ready     (ready_w[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)        state_nxt = BUSY;
      BUSY:    if (rel && !found) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q    <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      beat_cnt <= '0;
    end else if (!busy_w || rel) begin
      if (busy_w) ptr_q <= owner_inc;
      beat_cnt <= '0;
      if (found) begin
        gnt_q   <= N'(1) << pick;
        owner_q <= pick;
      end else begin
        gnt_q   <= '0;
        owner_q <= '0;
      end
    end else if (beat) begin
      beat_cnt <= beat_cnt + CW'(1);
    end
  end

  always_comb begin
    bus.gnt        = gnt_q;
    bus.ready      = ready_w;
    bus.owner      = owner_q;
    bus.busy       = busy_w;
    bus.fifo_wr_en = beat;
    bus.fifo_din   = din_v[owner_q];
  end
endmodule

// File: tb/tb_ip_fifo_wr_arb.sv
// Directed bench for ip_fifo_wr_arb: inputs change on the falling edge and
// outputs are checked 1ns later, well away from the rising edge.
module tb_ip_fifo_wr_arb;
  localparam int N = 4, WIDTH = 8, MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   nb;
  int   o;

  ip_fifo_wr_arb_if #(.N(N), .WIDTH(WIDTH)) bus ();

  ip_fifo_wr_arb #(.N(N), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = '0;
    bus.fifo_full = 1'b0;
    bus.din = 32'h44332211;
    #1;
    chk("rst_gnt",   bus.gnt, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_wr_en", bus.fifo_wr_en, 0);
    chk("rst_ready", bus.ready, 0);
    chk("rst_din",   bus.fifo_din, 8'h11);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req = '0;
    bus.din = '0;
    bus.fifo_full = 1'b0;

    // 1: single requester, 6 beats across a burst-limit re-grant
    do_reset();
    @(negedge clk); bus.req = 4'b0010; #1;
    chk("t1_idle_gnt", bus.gnt, 0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); bus.din[15:8] = 8'(8'hA0 + c); #1;
      chk("t1_gnt",   bus.gnt, 4'b0010);
      chk("t1_wr_en", bus.fifo_wr_en, 1);
      chk("t1_din",   bus.fifo_din, 8'hA0 + c);
      chk("t1_busy",  bus.busy, 1);
    end
    @(negedge clk); bus.req = '0; #1;
    chk("t1_drop_gnt",   bus.gnt, 4'b0010);
    chk("t1_drop_wr_en", bus.fifo_wr_en, 0);
    @(negedge clk); #1;
    chk("t1_idle_gnt2",  bus.gnt, 0);
    chk("t1_idle_busy",  bus.busy, 0);

    // 2: all requesting, rotation 0,1,2,3,0 with 4 beats each
    do_reset();
    @(negedge clk); bus.req = 4'b1111; #1;
    chk("t2_idle_gnt", bus.gnt, 0);
    nb = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); #1;
      o = ((c - 1) / 4) % 4;
      chk("t2_owner", bus.owner, o);
      chk("t2_gnt",   bus.gnt, 1 << o);
      chk("t2_ready", bus.ready, 1 << o);
      chk("t2_wr_en", bus.fifo_wr_en, 1);
      chk("t2_din",   bus.fifo_din, 8'h11 * (o + 1));
      nb += int'(bus.fifo_wr_en);
    end
    chk("t2_beats", nb, 20);

    // 3: full stalls owner 0 mid-burst without releasing
    do_reset();
    @(negedge clk); bus.req = 4'b0011; #1;
    chk("t3_idle_gnt", bus.gnt, 0);
    nb = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk); bus.fifo_full = (c >= 3 && c <= 5); #1;
      chk("t3_gnt", bus.gnt, 4'b0001);
      if (bus.fifo_full) begin
        chk("t3_full_wr_en", bus.fifo_wr_en, 0);
        chk("t3_full_ready", bus.ready, 0);
      end else begin
        chk("t3_wr_en", bus.fifo_wr_en, 1);
        chk("t3_ready", bus.ready, 4'b0001);
      end
      nb += int'(bus.fifo_wr_en);
    end
    chk("t3_beats", nb, 4);
    @(negedge clk); bus.fifo_full = 1'b0; #1;
    chk("t3_next_gnt",   bus.gnt, 4'b0010);
    chk("t3_next_owner", bus.owner, 1);

    // 4: owner 1 drops req after 2 beats; scan restarts at 2, not 0
    do_reset();
    @(negedge clk); bus.req = 4'b0010;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); #1;
      chk("t4_gnt",   bus.gnt, 4'b0010);
      chk("t4_wr_en", bus.fifo_wr_en, 1);
    end
    @(negedge clk); bus.req = 4'b0101; #1;
    chk("t4_rel_gnt",   bus.gnt, 4'b0010);
    chk("t4_rel_wr_en", bus.fifo_wr_en, 0);
    chk("t4_rel_busy",  bus.busy, 1);
    @(negedge clk); #1;
    chk("t4_new_gnt",   bus.gnt, 4'b0100);
    chk("t4_new_owner", bus.owner, 2);
    chk("t4_new_wr_en", bus.fifo_wr_en, 1);

    // 5: asynchronous reset mid-burst, then fresh arbitration from ptr 0
    do_reset();
    @(negedge clk); bus.req = 4'b0100;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); #1;
      chk("t5_gnt", bus.gnt, 4'b0100);
    end
    @(negedge clk); rst_n = 1'b0; #1;
    chk("t5_rst_gnt",   bus.gnt, 0);
    chk("t5_rst_wr_en", bus.fifo_wr_en, 0);
    chk("t5_rst_busy",  bus.busy, 0);
    @(negedge clk); rst_n = 1'b1; bus.req = 4'b1001; #1;
    chk("t5_idle_gnt", bus.gnt, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      chk("t5_gnt0",   bus.gnt, 4'b0001);
      chk("t5_wr_en0", bus.fifo_wr_en, 1);
    end
    @(negedge clk); #1;
    chk("t5_gnt3",   bus.gnt, 4'b1000);
    chk("t5_owner3", bus.owner, 3);

    // 6: idle with full toggling
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); bus.fifo_full = c[0]; #1;
      chk("t6_gnt",   bus.gnt, 0);
      chk("t6_busy",  bus.busy, 0);
      chk("t6_wr_en", bus.fifo_wr_en, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
